tdm_demux8: RTL and testbench
=============================

// Module: tdm_demux8
// PURPOSE
//  Time-division demultiplexer: inverse of the 8:1 mux. Takes one serial TDM stream
//  (slot 0 marked by frame_sync_i), steers each valid sample into its channel slot,
//  and publishes all CHANNELS samples as one parallel frame with a one-cycle valid.
//  Sits on the receive side of any link that serialises 8 channels through a mux.
// PARAMETERS
//  CHANNELS  8  channel slots per frame (power of two, >=2)
//  SEL_W     3  slot counter width, = log2(CHANNELS)
//  WIDTH     1  bits per sample
// PORTS
//  clk            in   1                 rising-edge clock
//  rst_n          in   1                 asynchronous active-low reset
//  din_i          in   WIDTH             serial sample
//  din_valid_i    in   1                 din_i/frame_sync_i qualified this cycle
//  frame_sync_i   in   1                 high with the slot-0 sample of every frame
//  chan_o         out  CHANNELS*WIDTH    frame; slot k at [k*WIDTH +: WIDTH]
//  frame_valid_o  out  1                 1-cycle pulse, chan_o newly updated
//  slot_o         out  SEL_W             slot the next valid sample will fill
//  locked_o       out  1                 1 in LOCKED state
//  sync_err_o     out  1                 1-cycle pulse on framing violation
// BEHAVIOUR
//  Reset (async assert, sync release): state=HUNT; chan_o, shadow reg, slot_o,
//   frame_valid_o, locked_o, sync_err_o all 0.
//  din_valid_i=0: no state/slot/shadow change; frame_valid_o and sync_err_o are 0.
//  frame_sync_i ignored unless din_valid_i=1.
//  FSM HUNT: valid & sync -> write sample to shadow slot 0, slot_o<=1, ->LOCKED.
//   valid & !sync -> sample dropped, stay HUNT, no error pulse.
//  FSM LOCKED, valid sample at slot s:
//   s==0 & sync    -> shadow[0]<=din, slot_o<=1.
//   s==0 & !sync   -> sample dropped, sync_err_o=1 next cycle, ->HUNT, slot_o<=0.
//   s!=0 & !sync   -> shadow[s]<=din, slot_o<=s+1 (wraps CHANNELS-1 -> 0).
//   s!=0 & sync    -> early sync: partial frame discarded (no frame_valid),
//                     sync_err_o=1, sample written as slot 0, slot_o<=1, stay LOCKED.
//   s==CHANNELS-1 & !sync -> chan_o <= {din, shadow[CHANNELS-2:0]} and
//                     frame_valid_o=1 in the following cycle; slot_o<=0.
//  Latency: last sample of frame on edge N -> chan_o/frame_valid_o visible after edge N.
//  chan_o holds last complete frame until next completion; never shows partial data.
//  Shadow slots not written since the last frame hold stale data (never exposed,
//   since only full frames publish).
//  Reset mid-frame: partial frame lost, chan_o cleared to 0, must re-hunt.
//  Registered outputs only; no combinational path input->output.
// TESTING (CHANNELS=8, WIDTH=1)
//  1 Reset, then 8 valid samples 1,0,1,1,0,0,1,0 (slot0..7) with sync on first ->
//    chan_o=8'b0100_1101, one frame_valid_o pulse, locked_o=1, slot_o=0.
//  2 Same frame with din_valid_i low for 3 cycles between slots 3 and 4 ->
//    identical chan_o, slot_o holds 4 during gap, single frame_valid_o pulse.
//  3 3 samples without sync in HUNT, then full frame 8'hA5 with sync ->
//    leading samples dropped, chan_o=8'hA5, sync_err_o never asserted.
//  4 Locked, sync asserted at slot 5 -> sync_err_o pulse, no frame_valid_o,
//    following 7 samples complete a frame realigned to that sync sample.
//  5 Locked, slot 0 arrives without sync -> sync_err_o pulse, locked_o=0,
//    chan_o retains previous frame (8'hA5).
//  6 rst_n low at slot 4 mid-frame -> all outputs 0 immediately (async), HUNT.

Source files
------------

// File: rtl/tdm_demux8.sv
// TDM demux: steers a serial slot stream into a shadow frame, publishes full frames only.
// Latency 1 cycle from last slot to chan_o/frame_valid_o; no backpressure, stalls when din_valid_i=0.
module tdm_demux8 #(
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int WIDTH    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          din_i,
  input  logic                      din_valid_i,
  input  logic                      frame_sync_i,
  output logic [CHANNELS*WIDTH-1:0] chan_o,
  output logic                      frame_valid_o,
  output logic [SEL_W-1:0]          slot_o,
  output logic                      locked_o,
  output logic                      sync_err_o
);

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [SEL_W-1:0]          slot_q, slot_d;
  logic [CHANNELS*WIDTH-1:0] shadow_q, shadow_d;
  logic [CHANNELS*WIDTH-1:0] chan_q, chan_d;
  logic                      fv_q, fv_d;
  logic                      err_q, err_d;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    chan_d   = chan_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;
    if (din_valid_i) begin
      if (state_q == HUNT) begin
        if (frame_sync_i) begin
          shadow_d[0 +: WIDTH] = din_i;
          slot_d               = SEL_W'(1);
          state_d              = LOCKED;
        end
      end else if (slot_q == '0) begin
        if (frame_sync_i) begin
          shadow_d[0 +: WIDTH] = din_i;
          slot_d               = SEL_W'(1);
        end else begin
          err_d   = 1'b1;
          state_d = HUNT;
          slot_d  = '0;
        end
      end else if (frame_sync_i) begin
        // Early sync: restart the frame on this sample, partial frame is abandoned.
        err_d                = 1'b1;
        shadow_d[0 +: WIDTH] = din_i;
        slot_d               = SEL_W'(1);
      end else begin
        shadow_d[int'(slot_q)*WIDTH +: WIDTH] = din_i;
        slot_d = slot_q + SEL_W'(1);
        if (slot_q == SEL_W'(CHANNELS-1)) begin
          chan_d = {din_i, shadow_q[(CHANNELS-1)*WIDTH-1:0]};
          fv_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      slot_q   <= '0;
      shadow_q <= '0;
      chan_q   <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      chan_q   <= chan_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
    end
  end

  assign chan_o        = chan_q;
  assign frame_valid_o = fv_q;
  assign slot_o        = slot_q;
  assign locked_o      = (state_q == LOCKED);
  assign sync_err_o    = err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8 (CHANNELS=8, WIDTH=1).
module tb_tdm_demux8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] din_i;
  logic       din_valid_i;
  logic       frame_sync_i;
  logic [7:0] chan_o;
  logic       frame_valid_o;
  logic [2:0] slot_o;
  logic       locked_o;
  logic       sync_err_o;

  int total = 0;
  int bad   = 0;

  tdm_demux8 #(.CHANNELS(8), .SEL_W(3), .WIDTH(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .din_i         (din_i),
    .din_valid_i   (din_valid_i),
    .frame_sync_i  (frame_sync_i),
    .chan_o        (chan_o),
    .frame_valid_o (frame_valid_o),
    .slot_o        (slot_o),
    .locked_o      (locked_o),
    .sync_err_o    (sync_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of input, then sample 1ns after the edge.
  task automatic step(input logic v, input logic d, input logic s);
    din_valid_i  = v;
    din_i        = d;
    frame_sync_i = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
  endtask

  logic [7:0] f1, f3, f4;

  initial begin
    f1 = 8'b0100_1101;
    f3 = 8'hA5;
    f4 = 8'h66;
    din_valid_i  = 1'b0;
    din_i        = 1'b0;
    frame_sync_i = 1'b0;

    do_reset();
    chk("rst_chan", chan_o, 8'h00);
    chk("rst_fv", frame_valid_o, 1'b0);
    chk("rst_slot", slot_o, 3'd0);
    chk("rst_lock", locked_o, 1'b0);
    chk("rst_err", sync_err_o, 1'b0);

    // Sync without valid must be ignored.
    step(1'b0, 1'b1, 1'b1);
    chk("novalid_sync_lock", locked_o, 1'b0);

    // 1: basic frame
    for (int i = 0; i < 8; i++) begin
      step(1'b1, f1[i], i == 0);
      chk("t1_slot", slot_o, 32'((i + 1) % 8));
      chk("t1_fv", frame_valid_o, i == 7);
    end
    chk("t1_chan", chan_o, f1);
    chk("t1_lock", locked_o, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("t1_fv_pulse", frame_valid_o, 1'b0);

    // 2: gap of 3 invalid cycles between slots 3 and 4
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'b1, 1'b1);
          chk("t2_gap_slot", slot_o, 3'd4);
          chk("t2_gap_fv", frame_valid_o, 1'b0);
        end
      end
      step(1'b1, f1[i], i == 0);
      chk("t2_fv", frame_valid_o, i == 7);
    end
    chk("t2_chan", chan_o, f1);
    chk("t2_slot", slot_o, 3'd0);

    // 3: re-hunt, leading unsynced samples dropped
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk("t3_hunt_slot", slot_o, 3'd0);
      chk("t3_hunt_err", sync_err_o, 1'b0);
      chk("t3_hunt_lock", locked_o, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, f3[i], i == 0);
      chk("t3_err", sync_err_o, 1'b0);
    end
    chk("t3_chan", chan_o, f3);
    chk("t3_fv", frame_valid_o, 1'b1);

    // 5: slot 0 without sync loses lock
    step(1'b1, 1'b0, 1'b0);
    chk("t5_err", sync_err_o, 1'b1);
    chk("t5_lock", locked_o, 1'b0);
    chk("t5_slot", slot_o, 3'd0);
    chk("t5_chan", chan_o, f3);
    step(1'b0, 1'b0, 1'b0);
    chk("t5_err_pulse", sync_err_o, 1'b0);

    // 4: relock, early sync at slot 5 realigns the frame
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i == 0);
    chk("t4_pre_slot", slot_o, 3'd5);
    step(1'b1, f4[0], 1'b1);
    chk("t4_err", sync_err_o, 1'b1);
    chk("t4_fv", frame_valid_o, 1'b0);
    chk("t4_slot", slot_o, 3'd1);
    chk("t4_lock", locked_o, 1'b1);
    chk("t4_chan_hold", chan_o, f3);
    for (int i = 1; i < 8; i++) begin
      step(1'b1, f4[i], 1'b0);
      chk("t4_fv_run", frame_valid_o, i == 7);
    end
    chk("t4_chan", chan_o, f4);
    chk("t4_err_clear", sync_err_o, 1'b0);

    // 6: async reset mid-frame
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, i == 0);
    chk("t6_pre_slot", slot_o, 3'd4);
    rst_n = 1'b0;
    #2;
    chk("t6_chan", chan_o, 8'h00);
    chk("t6_slot", slot_o, 3'd0);
    chk("t6_lock", locked_o, 1'b0);
    chk("t6_fv", frame_valid_o, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    chk("t6_rehunt_slot", slot_o, 3'd0);
    chk("t6_rehunt_lock", locked_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
